// File: rtl/lamp_frame_pkg.sv
// Constants, state encoding and helpers shared by the lamp-state frame
// transmitter and receiver.
package lamp_frame_pkg;

  localparam logic [7:0] TRAILER_BYTE  = 8'hEE;
  localparam int         PAYLOAD_BYTES = 14;
  localparam int         LAMP_WIDTH    = 104;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } frame_state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/frame_byte_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and strobes expire_o
// on the cycle the count reaches TIMEOUT_CYCLES-1 without a clear.
module frame_byte_timer #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic Sys_CLK,
  input  logic GlobalRst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // A clear in the same cycle (accepted byte) suppresses expiry.
  assign expire_o = enable_i && !clear_i && (count_q == LAST);

  always_ff @(posedge Sys_CLK or posedge GlobalRst) begin
    if (GlobalRst) begin
      count_q <= '0;
    end else if (clear_i || expire_o) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/lamp_frame_receiver.sv
// Reassembles counter + lamp-vector frames terminated by TRAILER_BYTE from the
// UART Rx byte stream; publishes good frames and counts dropped ones.
module lamp_frame_receiver
  import lamp_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  Sys_CLK,
  input  logic                  GlobalRst,
  input  logic [7:0]            RxData,
  input  logic                  RxData_valid,
  output logic                  RxData_ready,
  output logic [7:0]            frame_counter,
  output logic [LAMP_WIDTH-1:0] frame_lamp,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic                  locked,
  output logic [15:0]           good_count,
  output logic [15:0]           error_count
);

  frame_state_t          state_q;
  logic [3:0]            idx_q;
  logic [7:0]            stage_counter_q;
  logic [LAMP_WIDTH-1:0] stage_lamp_q;
  logic [7:0]            frame_counter_q;
  logic [LAMP_WIDTH-1:0] frame_lamp_q;
  logic                  frame_valid_q;
  logic                  frame_error_q;
  logic                  locked_q;
  logic [15:0]           good_count_q;
  logic [15:0]           error_count_q;

  logic accept;
  logic timer_expire;

  assign RxData_ready = !GlobalRst;
  assign accept       = RxData_valid && RxData_ready;

  frame_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .Sys_CLK  (Sys_CLK),
    .GlobalRst(GlobalRst),
    .clear_i  (accept || (state_q == HUNT)),
    .enable_i (state_q != HUNT),
    .expire_o (timer_expire)
  );

  always_ff @(posedge Sys_CLK or posedge GlobalRst) begin
    if (GlobalRst) begin
      state_q         <= HUNT;
      idx_q           <= '0;
      stage_counter_q <= '0;
      stage_lamp_q    <= '0;
      frame_counter_q <= '0;
      frame_lamp_q    <= '0;
      frame_valid_q   <= 1'b0;
      frame_error_q   <= 1'b0;
      locked_q        <= 1'b0;
      good_count_q    <= '0;
      error_count_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (accept && (RxData == TRAILER_BYTE)) begin
            state_q  <= PAYLOAD;
            idx_q    <= '0;
            locked_q <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            // Lamp bytes arrive MSB first, so shifting left lands byte 1 on top.
            if (idx_q == 4'd0) begin
              stage_counter_q <= RxData;
            end else begin
              stage_lamp_q <= {stage_lamp_q[LAMP_WIDTH-9:0], RxData};
            end
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'(PAYLOAD_BYTES - 1)) begin
              state_q <= TRAILER;
            end
          end else if (timer_expire) begin
            frame_error_q <= 1'b1;
            error_count_q <= sat_inc16(error_count_q);
            state_q       <= HUNT;
            locked_q      <= 1'b0;
          end
        end
        TRAILER: begin
          if (accept && (RxData == TRAILER_BYTE)) begin
            frame_counter_q <= stage_counter_q;
            frame_lamp_q    <= stage_lamp_q;
            frame_valid_q   <= 1'b1;
            good_count_q    <= sat_inc16(good_count_q);
            state_q         <= PAYLOAD;
            idx_q           <= '0;
          end else if (accept || timer_expire) begin
            frame_error_q <= 1'b1;
            error_count_q <= sat_inc16(error_count_q);
            state_q       <= HUNT;
            locked_q      <= 1'b0;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_counter = frame_counter_q;
  assign frame_lamp    = frame_lamp_q;
  assign frame_valid   = frame_valid_q;
  assign frame_error   = frame_error_q;
  assign locked        = locked_q;
  assign good_count    = good_count_q;
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_lamp_frame_receiver.sv
// Directed bench for lamp_frame_receiver with a 100-cycle inter-byte timeout.
module tb_lamp_frame_receiver;

  localparam int TMO = 100;
  localparam logic [103:0] LAMP_A = 104'h0102030405060708090A0B0C0D;
  localparam logic [103:0] LAMP_E = {13{8'hEE}};
  localparam logic [103:0] LAMP_C = 104'h2122232425262728292A2B2C2D;
  localparam logic [103:0] LAMP_D = 104'h1112131415161718191A1B1C1D;

  logic         Sys_CLK = 1'b0;
  logic         GlobalRst = 1'b1;
  logic [7:0]   RxData = 8'h00;
  logic         RxData_valid = 1'b0;
  logic         RxData_ready;
  logic [7:0]   frame_counter;
  logic [103:0] frame_lamp;
  logic         frame_valid;
  logic         frame_error;
  logic         locked;
  logic [15:0]  good_count;
  logic [15:0]  error_count;

  int checks = 0;
  int errors = 0;

  lamp_frame_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .Sys_CLK      (Sys_CLK),
    .GlobalRst    (GlobalRst),
    .RxData       (RxData),
    .RxData_valid (RxData_valid),
    .RxData_ready (RxData_ready),
    .frame_counter(frame_counter),
    .frame_lamp   (frame_lamp),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .locked       (locked),
    .good_count   (good_count),
    .error_count  (error_count)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  // One byte per clock; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge Sys_CLK);
    RxData = b;
    RxData_valid = 1'b1;
    @(posedge Sys_CLK);
    #1;
    RxData_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] cnt, input logic [103:0] lamp);
    send_byte(cnt);
    for (int k = 0; k < 13; k++) send_byte(lamp[103 - 8*k -: 8]);
  endtask

  task automatic idle_cycle();
    @(posedge Sys_CLK);
    #1;
  endtask

  task automatic test_reset();
    GlobalRst = 1'b1;
    #12;
    checks++;
    if ({frame_counter, frame_lamp, frame_valid, frame_error, locked, good_count, error_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cnt=%h lamp=%h v=%b e=%b lk=%b g=%h err=%h, want all 0",
               frame_counter, frame_lamp, frame_valid, frame_error, locked, good_count, error_count);
    end
    checks++;
    if (RxData_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", RxData_ready); end
    @(negedge Sys_CLK);
    GlobalRst = 1'b0;
    #1;
    checks++;
    if (RxData_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", RxData_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    send_byte(8'hEE);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL sync_locked: got %b want 1", locked); end
    send_payload(8'h05, LAMP_A);
    checks++;
    if (frame_valid !== 1'b0 || frame_counter !== 8'h00) begin
      errors++; $display("FAIL no_early_commit: got v=%b cnt=%h want v=0 cnt=00", frame_valid, frame_counter);
    end
    send_byte(8'hEE);
    checks++;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL frameA_valid: got %b want 1", frame_valid); end
    checks++;
    if (frame_counter !== 8'h05) begin errors++; $display("FAIL frameA_counter: got %h want 05", frame_counter); end
    checks++;
    if (frame_lamp !== LAMP_A) begin errors++; $display("FAIL frameA_lamp: got %h want %h", frame_lamp, LAMP_A); end
    checks++;
    if (good_count !== 16'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL frameA_good_locked: got g=%0d lk=%b want g=1 lk=1", good_count, locked);
    end
    idle_cycle();
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL frameA_strobe_width: got %b want 0", frame_valid); end
    $display("frame A cnt=%h lamp=%h", frame_counter, frame_lamp);
  endtask

  task automatic test_back_to_back();
    send_payload(8'h06, LAMP_E);
    send_byte(8'hEE);
    checks++;
    if (frame_valid !== 1'b1 || frame_counter !== 8'h06) begin
      errors++; $display("FAIL frameB_valid_cnt: got v=%b cnt=%h want v=1 cnt=06", frame_valid, frame_counter);
    end
    checks++;
    if (frame_lamp !== LAMP_E) begin errors++; $display("FAIL frameB_lamp: got %h want %h", frame_lamp, LAMP_E); end
    checks++;
    if (good_count !== 16'd2) begin errors++; $display("FAIL frameB_good: got %0d want 2", good_count); end
    $display("frame B cnt=%h lamp=%h", frame_counter, frame_lamp);
  endtask

  task automatic test_bad_trailer();
    send_payload(8'h07, LAMP_D);
    send_byte(8'h55);
    checks++;
    if (frame_error !== 1'b1 || error_count !== 16'd1) begin
      errors++; $display("FAIL bad_trailer_error: got e=%b cnt=%0d want e=1 cnt=1", frame_error, error_count);
    end
    checks++;
    if (frame_counter !== 8'h06 || frame_lamp !== LAMP_E || frame_valid !== 1'b0) begin
      errors++; $display("FAIL bad_trailer_hold: got cnt=%h lamp=%h v=%b want cnt=06 lamp=%h v=0",
                         frame_counter, frame_lamp, frame_valid, LAMP_E);
    end
    checks++;
    if (locked !== 1'b0 || good_count !== 16'd2) begin
      errors++; $display("FAIL bad_trailer_unlock: got lk=%b g=%0d want lk=0 g=2", locked, good_count);
    end
    send_byte(8'h06);
    send_byte(8'h12);
    send_byte(8'h34);
    checks++;
    if (locked !== 1'b0 || frame_error !== 1'b0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL hunt_ignore: got lk=%b e=%b v=%b want 0 0 0", locked, frame_error, frame_valid);
    end
    send_byte(8'hEE);
    send_payload(8'h08, LAMP_C);
    send_byte(8'hEE);
    checks++;
    if (frame_valid !== 1'b1 || frame_counter !== 8'h08 || frame_lamp !== LAMP_C || good_count !== 16'd3) begin
      errors++; $display("FAIL resync_frame: got v=%b cnt=%h lamp=%h g=%0d want v=1 cnt=08 lamp=%h g=3",
                         frame_valid, frame_counter, frame_lamp, good_count, LAMP_C);
    end
    $display("bad trailer: error_count=%0d, resync cnt=%h", error_count, frame_counter);
  endtask

  task automatic test_timeout();
    int early;
    for (int k = 0; k < 5; k++) send_byte(8'(8'h40 + k));
    early = 0;
    for (int c = 1; c < TMO; c++) begin
      idle_cycle();
      if (frame_error !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL timeout_early: got %0d early strobes want 0", early); end
    idle_cycle();
    checks++;
    if (frame_error !== 1'b1 || locked !== 1'b0 || error_count !== 16'd2) begin
      errors++; $display("FAIL timeout_fire: got e=%b lk=%b cnt=%0d want e=1 lk=0 cnt=2", frame_error, locked, error_count);
    end
    // Byte arriving on idle cycle 99 keeps the frame alive.
    send_byte(8'hEE);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h50 + k));
    for (int c = 1; c < TMO - 1; c++) idle_cycle();
    send_byte(8'h60);
    early = 0;
    for (int c = 1; c < TMO; c++) begin
      idle_cycle();
      if (frame_error !== 1'b0 || locked !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL timeout_late_byte: got %0d bad cycles want 0", early); end
    idle_cycle();
    checks++;
    if (frame_error !== 1'b1 || error_count !== 16'd3) begin
      errors++; $display("FAIL timeout_after_late_byte: got e=%b cnt=%0d want e=1 cnt=3", frame_error, error_count);
    end
    $display("timeout: error_count=%0d locked=%b", error_count, locked);
  endtask

  task automatic test_async_reset();
    int strobes;
    send_byte(8'hEE);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    #2;
    GlobalRst = 1'b1;
    #1;
    checks++;
    if ({frame_counter, frame_lamp, frame_valid, frame_error, locked, good_count, error_count} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got cnt=%h lamp=%h lk=%b g=%h err=%h want all 0",
               frame_counter, frame_lamp, locked, good_count, error_count);
    end
    @(negedge Sys_CLK);
    GlobalRst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 14; k++) begin
      send_byte(8'(8'h30 + k));
      if (frame_valid !== 1'b0 || frame_error !== 1'b0 || locked !== 1'b0) strobes++;
    end
    send_byte(8'h55);
    if (frame_valid !== 1'b0 || frame_error !== 1'b0 || locked !== 1'b0) strobes++;
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL unsynced_bytes: got %0d strobe cycles want 0", strobes); end
    $display("async reset: good=%0d err=%0d", good_count, error_count);
  endtask

  task automatic test_saturation();
    logic [15:0] want;
    @(negedge Sys_CLK);
    force dut.error_count_q = 16'hFFFE;
    @(posedge Sys_CLK);
    #1;
    release dut.error_count_q;
    idle_cycle();
    checks++;
    if (error_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want FFFE", error_count); end
    for (int n = 0; n < 3; n++) begin
      send_byte(8'hEE);
      send_payload(8'h09, LAMP_A);
      send_byte(8'h55);
      want = 16'hFFFF;
      checks++;
      if (frame_error !== 1'b1 || error_count !== want) begin
        errors++; $display("FAIL sat_bad_%0d: got e=%b cnt=%h want e=1 cnt=%h", n, frame_error, error_count, want);
      end
      $display("saturation frame %0d error_count=%h", n, error_count);
    end
    checks++;
    if (good_count !== 16'd0) begin errors++; $display("FAIL sat_good: got %0d want 0", good_count); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_bad_trailer();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/lamp_frame_receiver.md
Name: lamp_frame_receiver

Overview:
Receive-side counterpart of the lamp-state UART telemetry stream. It consumes bytes from the Uart controller's Rx handshake and reassembles frames of 14 payload bytes followed by trailer 0xEE. Payload is the 8-bit counter followed by the 104-bit lamp vector, MSB byte first. Validated frames are published as registered outputs with a one-cycle strobe; malformed frames are dropped, counted and resynchronised. Used for loopback self-check and for a second board mirroring lamp state.

Parameters:
PAYLOAD_BYTES, 14, payload bytes per frame (1 counter + 13 lamp)
TRAILER, 8'hEE, frame terminator and sync marker
TIMEOUT_CYCLES, 500000, max Sys_CLK cycles between bytes inside a frame (10 ms at 50 MHz)

Ports:
Sys_CLK  input  1  system clock
GlobalRst  input  1  reset (see Behaviour)
RxData  input  8  byte from Uart receiver
RxData_valid  input  1  RxData holds a byte
RxData_ready  output  1  receiver accepts byte
frame_counter  output  8  counter field of last good frame
frame_lamp  output  104  lamp field of last good frame
frame_valid  output  1  one-cycle strobe: new good frame committed
frame_error  output  1  one-cycle strobe: frame dropped
locked  output  1  1 while not in HUNT
good_count  output  16  good frames, saturating at 16'hFFFF
error_count  output  16  dropped frames, saturating at 16'hFFFF

Behaviour:
- Reset: GlobalRst, asynchronous, active-high; clock Sys_CLK. All outputs 0, state HUNT, byte index 0, timeout counter 0.
- Handshake: a byte is accepted on a rising edge with RxData_valid && RxData_ready. RxData_ready = 1 whenever not in reset; there is no back-pressure. Bytes arriving with valid low are ignored.
- States:
  - HUNT: discard bytes. On accepting TRAILER, go to PAYLOAD with idx=0. No error strobes in HUNT.
  - PAYLOAD: store the byte in a staging buffer. idx 0 goes to counter; idx k (1..13) goes to lamp[111-8k -: 8], so idx1 -> lamp[103:96] and idx13 -> lamp[7:0]. Increment idx. After accepting idx 13, go to TRAILER. Payload bytes equal to 0xEE are legal data.
  - TRAILER: if the byte equals TRAILER, copy staging to frame_counter/frame_lamp, pulse frame_valid, increment good_count, go to PAYLOAD with idx=0. Otherwise pulse frame_error, increment error_count, go to HUNT.
- Latency: frame_counter, frame_lamp and frame_valid update on the same edge that accepts the trailer. Outputs hold their values until the next good frame. Staging contents never leak to the outputs.
- Timeout:
  - In PAYLOAD or TRAILER, the counter increments each cycle with no accepted byte and clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES-1 with no byte: pulse frame_error, increment error_count, go to HUNT, clear the counter.
  - If a byte is accepted in that same cycle, the byte wins and there is no timeout.
  - The counter is held at 0 in HUNT.
- Counters saturate; they never wrap.
- locked = (state != HUNT), registered.
- Reset asserted mid-frame discards the partial frame and clears all outputs immediately, without waiting for a clock edge.

Decomposition:
- Shared package lamp_frame_pkg holds:
  - TRAILER_BYTE = 8'hEE
  - PAYLOAD_BYTES = 14
  - LAMP_WIDTH = 104
  - state encoding HUNT=2'd0, PAYLOAD=2'd1, TRAILER=2'd2
- The transmit-side frame builder uses the same constants.
- One sub-module, frame_byte_timer: an inter-byte timeout counter with clear/enable inputs and an expire strobe. It is parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then EE, 05, 13 bytes 01..0D, EE -> one frame_valid pulse; frame_counter=8'h05; frame_lamp=104'h0102030405060708090A0B0C0D; good_count=1; locked=1.
- Two back-to-back frames after a single leading EE; the second has counter 06, all lamp bytes EE, then trailer EE -> two frame_valid pulses; second frame_lamp = 13 bytes of EE, frame_counter=06.
- Sync, then 14 payload bytes followed by 8'h55 instead of EE -> frame_error pulse; error_count=1; outputs keep the previous frame; locked=0. Bytes until the next EE are ignored; the next full frame is accepted.
- Sync, 5 payload bytes, then idle TIMEOUT_CYCLES (bench override 100) -> frame_error exactly 100 cycles after the last byte; HUNT state. A byte arriving on cycle 99 instead does not time out.
- Assert GlobalRst asynchronously mid-payload -> all outputs 0 at once; after release, payload bytes without a leading EE produce no strobes.
- Force error_count to 16'hFFFE, inject 3 bad trailers -> error_count stops at 16'hFFFF.
